// File: rtl/bufram64c_pkg.sv
// Shared definitions for the 64-point FFT double-buffer sequencer:
// frame geometry, sequencer states and the read-address permutation.
package bufram64c_pkg;

    localparam int unsigned FFT_LEN = 64;
    localparam int unsigned AW      = 6;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_STREAM
    } state_t;

    // bitrev=0: 8x8 transpose (swap 3-bit halves); bitrev=1: full 6-bit reversal
    function automatic logic [AW-1:0] perm(input logic [AW-1:0] cnt, input logic bitrev);
        logic [AW-1:0] r;
        r = {cnt[2:0], cnt[5:3]};
        if (bitrev) begin
            for (int unsigned i = 0; i < AW; i++) begin
                r[i] = cnt[AW-1-i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bufram64c_perm.sv
// Combinational read-address permuter: transpose or bit-reverse of the
// frame counter, selected at elaboration time by MODE.
module bufram64c_perm
    import bufram64c_pkg::*;
#(
    parameter int unsigned MODE = 0
) (
    input  logic [AW-1:0] CNT,
    output logic [AW-1:0] ADDR
);

    always_comb begin
        ADDR = perm(CNT, MODE != 0);
    end

endmodule

// File: rtl/bufram64c_ctrl.sv
// Ping-pong address/control sequencer for the 2x64 complex FFT buffer:
// bank writes, permuted reads and a frame-aligned RDY/FRM after RDLAT.
module bufram64c_ctrl
    import bufram64c_pkg::*;
#(
    parameter int unsigned MODE  = 0,
    parameter int unsigned RDLAT = 2
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          ED,
    input  logic          START,
    output logic          WE,
    output logic          ODD,
    output logic [AW-1:0] ADDRW,
    output logic [AW-1:0] ADDRR,
    output logic          RDY,
    output logic          FRM
);

    state_t          state, state_n;
    logic [AW-1:0]   wcnt, wcnt_n;
    logic            odd_n, we_n;
    logic            rd_act, rd_act_n;
    logic            flush;
    logic [AW-1:0]   perm_addr;
    logic [AW-1:0]   addrr_n;
    logic [RDLAT-1:0] sr_v, sr_f;

    always_comb begin
        state_n  = state;
        wcnt_n   = wcnt;
        odd_n    = ODD;
        we_n     = WE;
        rd_act_n = rd_act;
        flush    = 1'b0;
        if (START) begin
            // START overrides everything, including a coincident wrap
            state_n  = ST_FILL;
            wcnt_n   = '0;
            odd_n    = 1'b0;
            we_n     = 1'b1;
            rd_act_n = 1'b0;
            flush    = 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                end
                ST_FILL, ST_STREAM: begin
                    wcnt_n = wcnt + 1'b1;
                    if (wcnt == AW'(FFT_LEN - 1)) begin
                        odd_n   = ~ODD;
                        state_n = ST_STREAM;
                    end
                    rd_act_n = (state_n == ST_STREAM);
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    // Read counter is the write counter itself, applied to the opposite bank
    bufram64c_perm #(
        .MODE(MODE)
    ) u_perm (
        .CNT  (wcnt_n),
        .ADDR (perm_addr)
    );

    always_comb begin
        addrr_n = rd_act_n ? perm_addr : '0;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state  <= ST_IDLE;
            wcnt   <= '0;
            ODD    <= 1'b0;
            WE     <= 1'b0;
            rd_act <= 1'b0;
            ADDRR  <= '0;
        end else if (ED) begin
            state  <= state_n;
            wcnt   <= wcnt_n;
            ODD    <= odd_n;
            WE     <= we_n;
            rd_act <= rd_act_n;
            ADDRR  <= addrr_n;
        end
    end

    always_comb begin
        ADDRW = wcnt;
    end

    // sr_f carries first-of-frame already qualified by valid, so RDY is a plain register tap
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sr_v <= '0;
            sr_f <= '0;
        end else if (ED) begin
            if (flush) begin
                sr_v <= '0;
                sr_f <= '0;
            end else begin
                sr_v[0] <= rd_act;
                sr_f[0] <= rd_act && (wcnt == '0);
                for (int unsigned i = 1; i < RDLAT; i++) begin
                    sr_v[i] <= sr_v[i-1];
                    sr_f[i] <= sr_f[i-1];
                end
            end
        end
    end

    always_comb begin
        FRM = sr_v[RDLAT-1];
        RDY = sr_f[RDLAT-1];
    end

endmodule

// File: tb/tb_bufram64c_ctrl.sv
// Randomized self-checking bench for bufram64c_ctrl; three configurations
// share the same stimulus and are checked against an ED-cycle-count model.
module tb_bufram64c_ctrl;

    logic CLK, RST, ED, START;

    logic       we0, odd0, rdy0, frm0;
    logic [5:0] aw0, ar0;
    logic       we1, odd1, rdy1, frm1;
    logic [5:0] aw1, ar1;
    logic       we2, odd2, rdy2, frm2;
    logic [5:0] aw2, ar2;

    int checks = 0;
    int errors = 0;
    // ED edges since the last accepted START; -1 when no START since reset
    int j = -1;

    bufram64c_ctrl #(.MODE(0), .RDLAT(2)) u0 (
        .CLK(CLK), .RST(RST), .ED(ED), .START(START),
        .WE(we0), .ODD(odd0), .ADDRW(aw0), .ADDRR(ar0), .RDY(rdy0), .FRM(frm0)
    );
    bufram64c_ctrl #(.MODE(1), .RDLAT(3)) u1 (
        .CLK(CLK), .RST(RST), .ED(ED), .START(START),
        .WE(we1), .ODD(odd1), .ADDRW(aw1), .ADDRR(ar1), .RDY(rdy1), .FRM(frm1)
    );
    bufram64c_ctrl #(.MODE(0), .RDLAT(1)) u2 (
        .CLK(CLK), .RST(RST), .ED(ED), .START(START),
        .WE(we2), .ODD(odd2), .ADDRW(aw2), .ADDRR(ar2), .RDY(rdy2), .FRM(frm2)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d (t=%0t j=%0d)", tag, got, exp, $time, j);
        end
    endtask

    function automatic int ref_perm(input int c, input int mode);
        int r, v;
        if (mode == 0) return (c % 8) * 8 + c / 8;
        r = 0;
        v = c;
        for (int b = 0; b < 6; b++) begin
            r = r * 2 + v % 2;
            v = v / 2;
        end
        return r;
    endfunction

    task automatic check_inst(input int idx, input int mode, input int rdlat,
                              input logic we, input logic odd,
                              input logic [5:0] aw, input logic [5:0] ar,
                              input logic rdy, input logic frm);
        int ewe, eodd, eaw, ear, erdy, efrm;
        ewe = 0; eodd = 0; eaw = 0; ear = 0; erdy = 0; efrm = 0;
        if (j >= 0) begin
            ewe  = 1;
            eaw  = j % 64;
            eodd = (j / 64) % 2;
            ear  = (j >= 64) ? ref_perm(j % 64, mode) : 0;
            efrm = (j >= 64 + rdlat) ? 1 : 0;
            erdy = (j >= 64 + rdlat && (j - 64 - rdlat) % 64 == 0) ? 1 : 0;
        end
        check($sformatf("u%0d.WE", idx),    32'(we),  32'(ewe));
        check($sformatf("u%0d.ODD", idx),   32'(odd), 32'(eodd));
        check($sformatf("u%0d.ADDRW", idx), 32'(aw),  32'(eaw));
        check($sformatf("u%0d.ADDRR", idx), 32'(ar),  32'(ear));
        check($sformatf("u%0d.RDY", idx),   32'(rdy), 32'(erdy));
        check($sformatf("u%0d.FRM", idx),   32'(frm), 32'(efrm));
    endtask

    task automatic check_all();
        check_inst(0, 0, 2, we0, odd0, aw0, ar0, rdy0, frm0);
        check_inst(1, 1, 3, we1, odd1, aw1, ar1, rdy1, frm1);
        check_inst(2, 0, 1, we2, odd2, aw2, ar2, rdy2, frm2);
    endtask

    // Called just after a falling edge; inputs settle well before the rising edge.
    task automatic cycle(input logic ed, input logic st);
        ED    = ed;
        START = st;
        @(posedge CLK);
        if (RST && ed) begin
            if (st) j = 0;
            else if (j >= 0) j++;
        end
        @(negedge CLK);
        check_all();
    endtask

    initial begin
        RST = 1'b0; ED = 1'b0; START = 1'b0;
        repeat (2) @(negedge CLK);
        check_all();
        #2 RST = 1'b1;
        @(negedge CLK);

        // idle after reset: no writes without START
        repeat (6) cycle(1'($urandom_range(0, 1)), 1'b0);

        // continuous ED stream
        cycle(1'b1, 1'b1);
        repeat (200) cycle(1'b1, 1'b0);

        // restart while streaming at write address 40
        for (int n = 0; n < 128; n++) begin
            if (j >= 64 && j % 64 == 40) break;
            cycle(1'b1, 1'b0);
        end
        check("restart_pos", 32'(j % 64), 32'd40);
        cycle(1'b1, 1'b1);
        repeat (150) cycle(1'b1, 1'b0);

        // START coincident with wrap, first in FILL then in STREAM
        cycle(1'b1, 1'b1);
        repeat (63) cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b1);
        repeat (130) cycle(1'b1, 1'b0);
        for (int n = 0; n < 64; n++) begin
            if (j % 64 == 63) break;
            cycle(1'b1, 1'b0);
        end
        check("wrap_pos", 32'(j % 64), 32'd63);
        cycle(1'b1, 1'b1);
        repeat (140) cycle(1'b1, 1'b0);

        // pseudo-random ED gaps with rare STARTs
        repeat (600) cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 399) == 0));

        // asynchronous reset mid-frame
        #2 RST = 1'b0;
        j = -1;
        #1 check_all();
        @(negedge CLK);
        #2 RST = 1'b1;
        @(negedge CLK);
        repeat (10) cycle(1'($urandom_range(0, 1)), 1'b0);
        cycle(1'b1, 1'b1);
        repeat (200) cycle(1'($urandom_range(0, 2) != 0), 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
